uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares a single UART transmitter between NUM_REQ byte requesters using round-robin arbitration.
- Accepts one byte per grant over a valid/ready handshake.
- Drives the transmitter's start pulse and data bus, then waits for the transmitter's done tick before granting again.
- A watchdog aborts a transfer if the transmitter never reports completion.
- Sits between the system-side message sources and the UART transmit datapath, mirroring the receive side's byte framing.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_SIZE, 8, bits per UART data byte (>=8 when UART_ARB_TAG_EN is defined)
TIMEOUT_CYCLES, 65535, clk cycles allowed between tx_start and tx_done_tick before abort (>=2)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  NUM_REQ*DATA_SIZE  packed bytes, requester i at [i*DATA_SIZE +: DATA_SIZE]
req_ready  out  NUM_REQ  one-hot accept; transfer occurs when req_valid[i] and req_ready[i] are both high
tx_start  out  1  one-cycle start pulse to the UART transmitter
tx_din  out  DATA_SIZE  byte to the transmitter; stable from the tx_start cycle until return to IDLE
tx_done_tick  in  1  transmitter end-of-stop-bit pulse
grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester
busy  out  1  high in any state except IDLE
timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset values (asynchronous, active-low): state IDLE, rr_ptr 0, tx_start 0, tx_din 0, grant_id 0, busy 0, timeout_err 0, wd_cnt 0.
- States: IDLE, START, WAIT.
- IDLE:
  - The winner is the first i with req_valid[i], scanning from rr_ptr upward with modulo-NUM_REQ wrap.
  - req_ready is combinational: one-hot on the winner, only while in IDLE. It is all zero when no valid is high and in every other state.
  - On a transfer: latch req_data[i] into tx_din, set grant_id=i, set rr_ptr=(i+1) mod NUM_REQ, go to START.
- START: tx_start=1 for exactly this cycle; clear wd_cnt; go to WAIT.
- WAIT:
  - wd_cnt increments each cycle.
  - tx_done_tick=1: go to IDLE.
  - Otherwise, if wd_cnt reaches TIMEOUT_CYCLES-1: pulse timeout_err, go to IDLE.
  - If done and timeout coincide, done wins and there is no error pulse.
- Latency:
  - valid high in IDLE → ready in the same cycle → tx_start on the next cycle.
  - After tx_done_tick, the earliest next grant is one cycle later (in IDLE).
- tx_done_tick outside WAIT is ignored.
- A requester dropping req_valid before acceptance is legal; arbitration re-evaluates every IDLE cycle.
- A requester never sees ready while another transfer is in flight, so back-to-back bytes from one source yield to other pending sources.
- Reset mid-operation: an accepted but unsent byte is discarded; rr_ptr returns to 0; no spurious tx_start is issued.

Optional Feature:
Macro UART_ARB_TAG_EN.
- Defined:
  - Each granted byte is preceded by a tag byte {4'hA, grant_id zero-extended to 4 bits}, upper bits zero when DATA_SIZE>8.
  - States become IDLE, TAG_START, TAG_WAIT, DATA_START, DATA_WAIT.
  - The watchdog runs independently in each WAIT state.
  - A timeout in TAG_WAIT aborts both bytes and pulses timeout_err.
  - busy stays high across both bytes.
- Not defined: one byte per grant, as above, with no tag logic synthesized.

Decomposition:
- Package uart_pkg holds:
  - the state enum, including the tag states;
  - TAG_MAGIC=4'hA;
  - the clog2 width helper.
- Sub-module uart_rr_picker: combinational rotate-priority picker. Inputs req_valid and rr_ptr; outputs a one-hot grant and an index. Instantiated once.

Test Plan:
1. Only req_valid[2] with data 0x5A → req_ready=4'b0100 for 1 cycle; next cycle tx_start=1 and tx_din=0x5A; tx_done_tick 100 cycles later → busy falls the next cycle; grant_id=2.
2. All four req_valid held high, done returned 10 cycles after each start → grant order 0,1,2,3,0; exactly one tx_start per grant.
3. rr_ptr=2 (after granting 1), req_valid=4'b1010 → requester 3 is granted first, then 1.
4. TIMEOUT_CYCLES=20 with no tx_done_tick → timeout_err pulses once, 20 cycles after tx_start; back to IDLE; a pending req_valid[0] is then granted normally. Done and timeout in the same cycle → no error pulse.
5. reset_n low for 1 cycle during WAIT → all outputs at reset values immediately; the next request goes to the lowest valid index from rr_ptr=0.
6. UART_ARB_TAG_EN defined, req 1 with data 0x33 → tx_din=0xA1 with tx_start, then after done tx_din=0x33 with a second tx_start; a timeout during the tag → no data byte sent, timeout_err pulses once.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM states, tag magic nibble and a width helper.
// The tag states are only reachable when UART_ARB_TAG_EN is defined.
package uart_pkg;

  localparam logic [3:0] TAG_MAGIC = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TAG_START,
    ST_TAG_WAIT,
    ST_DATA_START,
    ST_DATA_WAIT
  } arb_state_e;

  // Never returns 0 so a degenerate count still yields a legal vector width.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Rotate-priority picker: first valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
module uart_rr_picker
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = clog2w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);

  logic [NUM_REQ-1:0] rot;
  logic [IW-1:0]      off;
  logic [IW:0]        sum;

  always_comb begin
    // Rotating the doubled vector puts rr_ptr at bit 0, so the lowest set bit wins.
    rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
    any = |rot;
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
    idx = sum[IW-1:0];
    gnt = any ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between NUM_REQ byte sources, with a done watchdog.
// Define UART_ARB_TAG_EN to precede each granted byte with a {4'hA, grant_id} tag byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_SIZE      = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_start,
  output logic [DATA_SIZE-1:0]           tx_din,
  input  logic                           tx_done_tick,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int IW  = clog2w(NUM_REQ);
  localparam int WDW = clog2w(TIMEOUT_CYCLES);

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 tx_start_q, tx_start_d;
  logic [DATA_SIZE-1:0] tx_din_q, tx_din_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 tmo_q, tmo_d;
  logic [WDW-1:0]       wd_cnt_q, wd_cnt_d;
`ifdef UART_ARB_TAG_EN
  logic [DATA_SIZE-1:0] data_q, data_d;
`endif

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic [DATA_SIZE-1:0] pick_data;

  uart_rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .gnt       (pick_gnt),
    .idx       (pick_idx),
    .any       (pick_any)
  );

  assign pick_data   = req_data[pick_idx*DATA_SIZE +: DATA_SIZE];
  assign req_ready   = (state_q == ST_IDLE) ? pick_gnt : '0;
  assign tx_start    = tx_start_q;
  assign tx_din      = tx_din_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign timeout_err = tmo_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    tx_start_d = 1'b0;
    tx_din_d   = tx_din_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    tmo_d      = 1'b0;
    wd_cnt_d   = wd_cnt_q;
`ifdef UART_ARB_TAG_EN
    data_d     = data_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d    = pick_idx;
          rr_ptr_d   = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          busy_d     = 1'b1;
          tx_start_d = 1'b1;
`ifdef UART_ARB_TAG_EN
          data_d        = pick_data;
          tx_din_d      = '0;
          tx_din_d[7:0] = {TAG_MAGIC, 4'(pick_idx)};
          state_d       = ST_TAG_START;
`else
          tx_din_d   = pick_data;
          state_d    = ST_DATA_START;
`endif
        end
      end
      ST_TAG_START, ST_DATA_START: begin
        wd_cnt_d = '0;
        state_d  = (state_q == ST_TAG_START) ? ST_TAG_WAIT : ST_DATA_WAIT;
      end
      ST_TAG_WAIT, ST_DATA_WAIT: begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        // Done is checked first so a coincident timeout is not reported.
        if (tx_done_tick) begin
`ifdef UART_ARB_TAG_EN
          if (state_q == ST_TAG_WAIT) begin
            tx_start_d = 1'b1;
            tx_din_d   = data_q;
            state_d    = ST_DATA_START;
          end else
`endif
          begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (wd_cnt_q == WDW'(TIMEOUT_CYCLES - 2)) begin
          tmo_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      tx_start_q <= 1'b0;
      tx_din_q   <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      tmo_q      <= 1'b0;
      wd_cnt_q   <= '0;
`ifdef UART_ARB_TAG_EN
      data_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      tx_start_q <= tx_start_d;
      tx_din_q   <= tx_din_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      tmo_q      <= tmo_d;
      wd_cnt_q   <= wd_cnt_d;
`ifdef UART_ARB_TAG_EN
      data_q     <= data_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected (grant, byte) pairs are queued as stimulus is
// driven and popped on every tx_start; a small transmitter model returns done after done_dly cycles.
module tb_uart_tx_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int TMO = 128;
`ifdef UART_ARB_TAG_EN
  localparam int BPG = 2;
`else
  localparam int BPG = 1;
`endif

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] b;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    req_ready;
  logic             tx_start;
  logic [DW-1:0]    tx_din;
  logic             tx_done_tick = 1'b0;
  logic [1:0]       grant_id;
  logic             busy;
  logic             timeout_err;

  exp_t exp_q[$];
  int tests = 0, fails = 0;
  int n_start = 0, n_tmo = 0;
  int done_dly = 10, done_cnt = -1;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_SIZE(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .grant_id     (grant_id),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // Scoreboard check on each start, plus the transmitter's done-tick model.
  always @(negedge clk) begin
    exp_t e;
    tx_done_tick = 1'b0;
    if (reset_n) begin
      if (timeout_err) n_tmo++;
      if (tx_start) begin
        n_start++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected_start: got id=%0d din=%h, required no start", grant_id, tx_din);
        end else begin
          e = exp_q.pop_front();
          if ({grant_id, tx_din} !== e) begin
            fails++;
            $display("FAIL sb_byte: got id=%0d din=%h, required id=%0d din=%h", grant_id, tx_din, e.id, e.b);
          end
        end
      end
      if (tx_start && done_dly > 0) done_cnt = done_dly;
      else if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          tx_done_tick = 1'b1;
          done_cnt = -1;
        end
      end
    end
  end

  task automatic set_data(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic push_tag(input logic [1:0] id);
    exp_t e;
    e.id = id;
    e.b  = {4'hA, 2'b00, id};
    exp_q.push_back(e);
  endtask

  task automatic push_grant(input logic [1:0] id, input logic [DW-1:0] b);
    exp_t e;
`ifdef UART_ARB_TAG_EN
    push_tag(id);
`endif
    e.id = id;
    e.b  = b;
    exp_q.push_back(e);
  endtask

  task automatic do_reset;
    reset_n   = 1'b0;
    req_valid = '0;
    exp_q.delete();
    done_cnt  = -1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_starts(input int target, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk); #1;
      if (n_start >= target) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk); #1;
      cyc++;
    end while (busy && cyc < 2000);
  endtask

  task automatic run_grants(input logic [NR-1:0] v, input int n, input string nm);
    bit ok;
    int cyc;
    req_valid = v;
    wait_starts(n_start + n * BPG, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL %s_starts: got %0d starts total, required %0d more", nm, n_start, n * BPG); end
    req_valid = '0;
    wait_idle(cyc);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL %s_drain: got %0d pending, required 0", nm, exp_q.size()); end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    req_valid = '0;
    #1;
    tests++;
    if ({tx_start, busy, timeout_err, grant_id} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl: got start=%b busy=%b tmo=%b gid=%0d, required all 0", tx_start, busy, timeout_err, grant_id);
    end
    tests++;
    if (tx_din !== '0 || req_ready !== '0) begin
      fails++; $display("FAIL reset_data: got din=%h ready=%b, required 0/0", tx_din, req_ready);
    end
  endtask

  task automatic test_single;
    int cyc;
    do_reset();
    done_dly = 100;
    set_data(2, 8'h5A);
    push_grant(2, 8'h5A);
    req_valid = 4'b0100;
    #1;
    tests++;
    if (req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready: got %b, required 0100", req_ready); end
    @(negedge clk); #1;
    tests++;
    if (tx_start !== 1'b1 || req_ready !== 4'b0000) begin
      fails++; $display("FAIL single_start: got start=%b ready=%b, required 1/0000", tx_start, req_ready);
    end
    req_valid = '0;
    wait_idle(cyc);
    tests++;
    if (cyc != BPG * 101) begin fails++; $display("FAIL single_busy_fall: got %0d cycles, required %0d", cyc, BPG * 101); end
    tests++;
    if (grant_id !== 2'd2 || exp_q.size() != 0) begin
      fails++; $display("FAIL single_grant: got gid=%0d pending=%0d, required 2/0", grant_id, exp_q.size());
    end
  endtask

  task automatic test_all_valid;
    int s0;
    do_reset();
    done_dly = 10;
    for (int i = 0; i < NR; i++) set_data(i, 8'h10 + 8'(i));
    push_grant(0, 8'h10); push_grant(1, 8'h11); push_grant(2, 8'h12); push_grant(3, 8'h13); push_grant(0, 8'h10);
    s0 = n_start;
    run_grants(4'b1111, 5, "all");
    repeat (3) @(negedge clk); #1;
    tests++;
    if (n_start - s0 != 5 * BPG) begin fails++; $display("FAIL all_count: got %0d starts, required %0d", n_start - s0, 5 * BPG); end
  endtask

  task automatic test_rr_ptr;
    do_reset();
    done_dly = 10;
    set_data(1, 8'h21);
    push_grant(1, 8'h21);
    run_grants(4'b0010, 1, "ptr_first");
    set_data(1, 8'h41);
    set_data(3, 8'h43);
    push_grant(3, 8'h43);
    push_grant(1, 8'h41);
    run_grants(4'b1010, 2, "ptr_wrap");
  endtask

  task automatic test_timeout;
    bit ok;
    int cyc, t0;
    do_reset();
    done_dly = 0;
    t0 = n_tmo;
    set_data(0, 8'h77);
`ifdef UART_ARB_TAG_EN
    push_tag(0);
`else
    push_grant(0, 8'h77);
`endif
    req_valid = 4'b0001;
    wait_starts(n_start + 1, ok);
    set_data(0, 8'h78);
    cyc = 0;
    do begin
      @(negedge clk); #1;
      cyc++;
    end while (!timeout_err && cyc < 1000);
    tests++;
    if (cyc != TMO) begin fails++; $display("FAIL tmo_latency: got %0d cycles, required %0d", cyc, TMO); end
    done_dly = 10;
    push_grant(0, 8'h78);
    t0 = t0 + 1;
    wait_starts(n_start + BPG, ok);
    req_valid = '0;
    wait_idle(cyc);
    tests++;
    if (!ok || n_tmo != t0 || exp_q.size() != 0) begin
      fails++; $display("FAIL tmo_recover: got ok=%0d pulses=%0d pending=%0d, required 1/%0d/0", ok, n_tmo, exp_q.size(), t0);
    end
    // Done arriving on the watchdog's last cycle must not raise an error.
    do_reset();
    done_dly = TMO - 1;
    t0 = n_tmo;
    set_data(0, 8'h55);
    push_grant(0, 8'h55);
    req_valid = 4'b0001;
    wait_starts(n_start + 1, ok);
    req_valid = '0;
    wait_idle(cyc);
    tests++;
    if (cyc != BPG * TMO || n_tmo != t0) begin
      fails++; $display("FAIL tmo_coincide: got %0d cycles, %0d pulses, required %0d cycles, %0d pulses", cyc, n_tmo, BPG * TMO, t0);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    do_reset();
    done_dly = 0;
    set_data(2, 8'h99);
    push_grant(2, 8'h99);
    req_valid = 4'b0100;
    wait_starts(n_start + 1, ok);
    set_data(1, 8'h31);
    set_data(3, 8'h33);
    req_valid = 4'b1010;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests++;
    if ({tx_start, busy, timeout_err, grant_id} !== 5'b0 || tx_din !== '0) begin
      fails++; $display("FAIL midreset_out: got start=%b busy=%b tmo=%b gid=%0d din=%h, required all 0", tx_start, busy, timeout_err, grant_id, tx_din);
    end
    exp_q.delete();
    done_cnt = -1;
    done_dly = 10;
    push_grant(1, 8'h31);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0010) begin fails++; $display("FAIL midreset_ready: got %b, required 0010", req_ready); end
    run_grants(4'b1010, 1, "midreset");
  endtask

`ifdef UART_ARB_TAG_EN
  task automatic test_tag;
    do_reset();
    done_dly = 10;
    set_data(1, 8'h33);
    req_valid = 4'b0010;
    push_grant(1, 8'h33);
    @(negedge clk); #1;
    tests++;
    if (tx_start !== 1'b1 || tx_din !== 8'hA1) begin
      fails++; $display("FAIL tag_first: got start=%b din=%h, required 1/a1", tx_start, tx_din);
    end
    run_grants(4'b0010, 0, "tag");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_valid();
    test_rr_ptr();
    test_timeout();
    test_reset_mid();
`ifdef UART_ARB_TAG_EN
    test_tag();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: bench did not reach its summary, required completion");
    $fatal(1, "time limit");
  end

endmodule
